neuron_mac: RTL

- Serial fixed-point neuron. Consumes the 16-bit pixel words produced by the pixel-conversion stage (binary pixel -> 0x0400 = 1.0 or 0x0000), one per handshake.
- Multiplies each word by a per-input weight, accumulates NIN products, adds the bias, then saturates to 16 bits.
- Presents one neuron output to the next layer through a valid/ready handshake.

---
 rtl/neuron_mac_if.sv | 32 +++
 rtl/neuron_mac.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/neuron_mac_if.sv
`default_nettype none
// ============================================================================
// neuron_mac_if : pixel-in / weight-lookup / result-out bundle for neuron_mac
// Rev 1.0
// ============================================================================
interface neuron_mac_if #(
  parameter int DWIDTH = 16,
  parameter int IWIDTH = 64
) ();
  logic                      start;
  logic                      in_valid;
  logic                      in_ready;
  logic [DWIDTH-1:0]         in_data;
  logic [$clog2(IWIDTH)-1:0] waddr;
  logic [DWIDTH-1:0]         weight;
  logic [DWIDTH-1:0]         bias;
  logic                      out_valid;
  logic                      out_ready;
  logic [DWIDTH-1:0]         out_data;
  logic                      busy;

  modport master (
    output start, in_valid, in_data, weight, bias, out_ready,
    input  in_ready, waddr, out_valid, out_data, busy
  );

  modport slave (
    input  start, in_valid, in_data, weight, bias, out_ready,
    output in_ready, waddr, out_valid, out_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/neuron_mac.sv
`default_nettype none
// ============================================================================
// neuron_mac : serial Q5.10 multiply-accumulate neuron with saturated output;
//              defining NEURON_RELU_EN clamps negative results to zero.
// Rev 1.0
// ============================================================================
module neuron_mac #(
  parameter int DWIDTH = 16,
  parameter int FRAC   = 10,
  parameter int IWIDTH = 64,
  parameter int AWIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  neuron_mac_if.slave bus
);
  localparam int CW = $clog2(IWIDTH);
  localparam logic [CW-1:0] c_last = CW'(IWIDTH - 1);
  localparam logic signed [AWIDTH-1:0] c_sat_max =
    {{(AWIDTH-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
  localparam logic signed [AWIDTH-1:0] c_sat_min =
    {{(AWIDTH-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    BIAS = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic signed [AWIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     busy_q, busy_d;
  logic [DWIDTH-1:0]        out_data_q, out_data_d;

  logic signed [DWIDTH-1:0]   data_s, weight_s, bias_s;
  logic signed [2*DWIDTH-1:0] prod, prod_sh;
  logic signed [AWIDTH-1:0]   prod_ext, bias_sum;
  logic [DWIDTH-1:0]          sat_val, res_val;
  logic                       beat;

  // Datapath: full-precision product rescaled by an arithmetic shift (floor).
  always_comb begin
    data_s   = bus.in_data;
    weight_s = bus.weight;
    bias_s   = bus.bias;
    prod     = (2*DWIDTH)'(data_s) * (2*DWIDTH)'(weight_s);
    prod_sh  = prod >>> FRAC;
    prod_ext = AWIDTH'(prod_sh);
    bias_sum = acc_q + AWIDTH'(bias_s);

    if (bias_sum > c_sat_max) begin
      sat_val = c_sat_max[DWIDTH-1:0];
    end else if (bias_sum < c_sat_min) begin
      sat_val = c_sat_min[DWIDTH-1:0];
    end else begin
      sat_val = bias_sum[DWIDTH-1:0];
    end

`ifdef NEURON_RELU_EN
    res_val = sat_val[DWIDTH-1] ? '0 : sat_val;
`else
    res_val = sat_val;
`endif
  end

  always_comb begin
    beat       = (state_q == ACC) && bus.in_valid && in_ready_q;
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACC;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      ACC: begin
        if (beat) begin
          acc_d = acc_q + prod_ext;
          if (cnt_q == c_last) begin
            cnt_d   = '0;
            state_d = BIAS;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      BIAS: begin
        acc_d      = bias_sum;
        out_data_d = res_val;
        state_d    = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags follow the next state so they are registered, not decoded.
    in_ready_d  = (state_d == ACC);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;
  assign bus.waddr     = cnt_q;

endmodule
`default_nettype wire
